// File: rtl/uwasic_onboarding_miranda.sv
// TinyTapeout onboarding tile: a write-only SPI slave (mode 0) loads a 5-register bank that drives 16 static/PWM outputs.
// Optional build macro PWM_SYNC_UPDATE_EN: duty writes go to a shadow register that is applied only at the PWM wrap.
module uwasic_onboarding_miranda #(
  parameter int PWM_PERIOD  = 3333,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int               CNT_W     = $clog2(PWM_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PWM_PERIOD - 1);
  localparam logic [4:0]       BITS_FULL = 5'd16;
  localparam logic [4:0]       BITS_SAT  = 5'd17;
  localparam logic [6:0]       ADDR_LAST = 7'd4;

  typedef enum logic {
    S_IDLE,
    S_RECV
  } spi_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_q;
  logic                   ncs_q;
  logic                   sclk_s;
  logic                   copi_s;
  logic                   ncs_s;
  logic                   sclk_rise;
  logic                   ncs_fall;
  logic                   ncs_rise;

  // nCS resets to 0 so a pin still held low at reset release cannot fake a
  // falling edge; the next frame must begin with a genuine high-to-low.
  // NOTE: sequential state is always written with non-blocking (<=) assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ui_in[0]};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], ui_in[1]};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ui_in[2]};
      sclk_q    <= sclk_s;
      ncs_q     <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign ncs_fall  = ~ncs_s & ncs_q;
  assign ncs_rise  = ncs_s & ~ncs_q;

  // ---------------------------------------------------------------------------
  // Frame control FSM
  // ---------------------------------------------------------------------------
  spi_state_t state;
  spi_state_t state_nxt;
  logic       frame_clr;
  logic       frame_shift;
  logic       frame_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_nxt   = state;
    frame_clr   = 1'b0;
    frame_shift = 1'b0;
    frame_end   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ncs_fall) begin
          state_nxt = S_RECV;
          frame_clr = 1'b1;
        end
      end
      S_RECV: begin
        if (ncs_rise) begin
          state_nxt = S_IDLE;
          frame_end = 1'b1;
        end else if (sclk_rise) begin
          frame_shift = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift register and saturating bit counter
  // ---------------------------------------------------------------------------
  logic [15:0] shift_q;
  logic [4:0]  bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (frame_clr) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (frame_shift) begin
      shift_q <= {shift_q[14:0], copi_s};
      if (bit_cnt != BITS_SAT) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty_reg;
  logic [7:0]  duty;

  assign wr_addr = shift_q[14:8];
  assign wr_data = shift_q[7:0];
  assign wr_en   = frame_end && (bit_cnt == BITS_FULL) && shift_q[15] && (wr_addr <= ADDR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out   <= '0;
      en_pwm   <= '0;
      duty_reg <= '0;
    end else if (wr_en) begin
      case (wr_addr[2:0])
        3'd0:    en_out[7:0]  <= wr_data;
        3'd1:    en_out[15:8] <= wr_data;
        3'd2:    en_pwm[7:0]  <= wr_data;
        3'd3:    en_pwm[15:8] <= wr_data;
        3'd4:    duty_reg     <= wr_data;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // PWM generator
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] pwm_cnt;
  logic [19:0]      duty_prod;
  logic [19:0]      duty_thr;
  logic             pwm_sig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == CNT_MAX) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + CNT_W'(1);
    end
  end

`ifdef PWM_SYNC_UPDATE_EN
  // duty_reg acts as the shadow; the active value only moves at the wrap so
  // a period in flight is never cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= '0;
    end else if (pwm_cnt == CNT_MAX) begin
      duty <= duty_reg;
    end
  end
`else
  assign duty = duty_reg;
`endif

  assign duty_prod = 20'(duty) * 20'(PWM_PERIOD);
  assign duty_thr  = duty_prod >> 8;

  // Full scale is forced high; the scaled threshold alone would leave a short low tail.
  always_comb begin
    pwm_sig = 1'b0;
    if (duty == 8'hFF) begin
      pwm_sig = 1'b1;
    end else if (duty != 8'h00) begin
      pwm_sig = (20'(pwm_cnt) < duty_thr);
    end
  end

  // ---------------------------------------------------------------------------
  // Channel outputs
  // ---------------------------------------------------------------------------
  logic [15:0] ch;

  assign ch      = en_out & (~en_pwm | {16{pwm_sig}});
  assign uo_out  = ch[7:0];
  assign uio_out = ch[15:8];
  assign uio_oe  = 8'hFF;

  logic unused;
  assign unused = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_miranda.sv
// Scoreboard bench for uwasic_onboarding_miranda: stimulus pushes model snapshots,
// a monitor measures per-channel high time (or period) over a window and compares.
module tb_uwasic_onboarding_miranda;

  localparam int         PWM_PERIOD = 3333;
  localparam logic [1:0] K_COUNT    = 2'd0;
  localparam logic [1:0] K_PERIOD   = 2'd1;
  localparam int         DRAIN_LIM  = 20000;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [31:0] ncycles;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic [15:0] ch_obs;
  assign ch_obs = {uio_out, uo_out};

  uwasic_onboarding_miranda #(
    .PWM_PERIOD (PWM_PERIOD),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    n_compared;
  int    n_mismatched;
  logic  busy;
  exp_t  exp_q[$];
  string name_q[$];
  logic [7:0] model [5];

  task automatic check(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a frame writes only if exactly 16 bits, write flag set, address 0..4.
  task automatic model_frame(input logic [16:0] bits, input int n);
    int idx;
    idx = int'(bits[14:8]);
    if (n == 16 && bits[15] && idx <= 4) model[idx] = bits[7:0];
  endtask

  task automatic model_reset();
    foreach (model[i]) model[i] = 8'h00;
  endtask

  function automatic exp_t snap(input logic [1:0] kind, input int n);
    exp_t e;
    e.kind    = kind;
    e.en_out  = {model[1], model[0]};
    e.en_pwm  = {model[3], model[2]};
    e.duty    = model[4];
    e.ncycles = 32'(n);
    return e;
  endfunction

  // Expected high cycles of channel i over n cycles (n a whole number of periods when PWM is live).
  function automatic int exp_high(input exp_t e, input int i, input int n);
    int h;
    if (!e.en_out[i]) return 0;
    if (!e.en_pwm[i]) return n;
    if (e.duty == 8'd0) h = 0;
    else if (e.duty == 8'd255) h = PWM_PERIOD;
    else h = (int'(e.duty) * PWM_PERIOD) / 256;
    return h * (n / PWM_PERIOD);
  endfunction

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < DRAIN_LIM) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || busy) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL monitor drain: still busy after %0d cycles, expected idle", t);
    end
  endtask

  task automatic push(input string nm, input logic [1:0] kind, input int n);
    exp_q.push_back(snap(kind, n));
    name_q.push_back(nm);
  endtask

  task automatic observe(input string nm, input int n);
    push(nm, K_COUNT, n);
    drain();
  endtask

  task automatic spi_bit(input logic b);
    ui_in[1] = b;
    tick(3);
    ui_in[0] = 1'b1;
    tick(3);
    ui_in[0] = 1'b0;
  endtask

  task automatic send_frame(input logic [16:0] bits, input int n);
    ui_in[2] = 1'b0;
    tick(4);
    for (int k = n - 1; k >= 0; k--) spi_bit(bits[k]);
    tick(4);
    ui_in[2] = 1'b1;
    tick(8);
    model_frame(bits, n);
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    send_frame({1'b0, 1'b1, addr, data}, 16);
  endtask

  task automatic settle();
    tick(PWM_PERIOD + 8);
  endtask

  task automatic measure_period(input exp_t e, input string nm);
    int   t;
    int   per;
    int   hi;
    logic prev;
    t = 0;
    do begin
      prev = ch_obs[0];
      @(negedge clk);
      t++;
    end while (!(ch_obs[0] && !prev) && t < 3 * PWM_PERIOD);
    if (!(ch_obs[0] && !prev)) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL %s: no rising edge on ch0 within %0d cycles", nm, t);
    end else begin
      per = 0;
      hi  = 0;
      do begin
        hi += int'(ch_obs[0]);
        prev = ch_obs[0];
        @(negedge clk);
        per++;
      end while (!(ch_obs[0] && !prev) && per < 3 * PWM_PERIOD);
      check({nm, " period"}, per, int'(e.ncycles));
      check({nm, " high time"}, hi, exp_high(e, 0, PWM_PERIOD));
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    int    cnt [16];
    busy = 1'b0;
    forever begin
      while (exp_q.size() == 0) @(negedge clk);
      busy = 1'b1;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check({nm, " uio_oe"}, int'(uio_oe), 255);
      if (e.kind == K_COUNT) begin
        foreach (cnt[i]) cnt[i] = 0;
        for (int c = 0; c < int'(e.ncycles); c++) begin
          @(negedge clk);
          for (int i = 0; i < 16; i++) cnt[i] += int'(ch_obs[i]);
        end
        for (int i = 0; i < 16; i++)
          check($sformatf("%s ch%0d high", nm, i), cnt[i], exp_high(e, i, int'(e.ncycles)));
      end else begin
        measure_period(e, nm);
      end
      busy = 1'b0;
    end
  end

  initial begin : watchdog
    #(10 * 150000);
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [16:0] bits;
    logic [15:0] mid_bits;
    logic [15:0] stale_bits;
    logic [6:0]  a;
    int          len;

    n_compared   = 0;
    n_mismatched = 0;
    model_reset();
    rst    = 1'b0;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h04;
    #3 rst = 1'b1;

    // Reset with random SPI activity on the pins.
    tick(2);
    push("in reset", K_COUNT, 100);
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
    end
    drain();
    ui_in = 8'h04;
    tick(4);
    rst = 1'b0;
    tick(8);
    observe("after reset", 200);

    // Static enables.
    spi_write(7'h00, 8'hF0);
    spi_write(7'h01, 8'h01);
    observe("static", 2 * PWM_PERIOD);

    // 50% PWM on channel 0, then the duty extremes.
    spi_write(7'h00, 8'h01);
    spi_write(7'h02, 8'h01);
    spi_write(7'h04, 8'h80);
    settle();
    push("pwm50", K_PERIOD, PWM_PERIOD);
    drain();
    observe("pwm50 window", PWM_PERIOD);
    spi_write(7'h04, 8'h00);
    settle();
    observe("duty 0x00", PWM_PERIOD);
    spi_write(7'h04, 8'hFF);
    settle();
    observe("duty 0xFF", PWM_PERIOD);

    // Invalid frames must leave every register alone.
    spi_write(7'h02, 8'h00);
    spi_write(7'h00, 8'hA5);
    spi_write(7'h01, 8'h3C);
    observe("invalid baseline", 100);
    send_frame({1'b0, 1'b0, 7'h00, 8'hFF}, 16);
    observe("read frame", 100);
    send_frame({1'b0, 1'b1, 7'h05, 8'hFF}, 16);
    observe("addr 0x05", 100);
    send_frame({1'b0, 1'b1, 7'h40, 8'h5A}, 16);
    observe("addr 0x40", 100);
    send_frame({2'b00, 15'h402D}, 15);
    observe("15-bit frame", 100);
    send_frame({1'b1, 1'b1, 7'h01, 8'h5A}, 17);
    observe("17-bit frame lead", 100);
    send_frame({1'b1, 7'h00, 8'h5A, 1'b1}, 17);
    observe("17-bit frame tail", 100);

    // Mixed static and PWM channels.
    spi_write(7'h00, 8'hFF);
    spi_write(7'h01, 8'hFF);
    spi_write(7'h02, 8'hFF);
    spi_write(7'h03, 8'h00);
    spi_write(7'h04, 8'h40);
    settle();
    observe("mixed", PWM_PERIOD);

    // Randomized frames against the reference model.
    for (int r = 0; r < 6; r++) begin
      case ($urandom_range(0, 5))
        0:       len = 15;
        5:       len = 17;
        default: len = 16;
      endcase
      a    = 7'($urandom_range(0, 5));
      bits = {1'($urandom), ($urandom_range(0, 5) != 0), a, 8'($urandom)};
      send_frame(bits, len);
      if (len == 16 && bits[15] && a == 7'd4) settle();
      observe($sformatf("random %0d", r), PWM_PERIOD);
    end

    // Reset in the middle of a frame.
    mid_bits   = 16'h80AA;
    stale_bits = 16'h8055;
    ui_in[2] = 1'b0;
    tick(4);
    for (int k = 15; k >= 8; k--) spi_bit(mid_bits[k]);
    rst = 1'b1;
    model_reset();
    observe("reset mid-frame", 16);
    tick(2);
    rst = 1'b0;
    tick(4);
    for (int k = 15; k >= 0; k--) spi_bit(stale_bits[k]);
    tick(4);
    ui_in[2] = 1'b1;
    tick(8);
    observe("frame spanning reset", 100);
    spi_write(7'h00, 8'h3C);
    observe("write after reset", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
